dvfs_vf_sequencer: RTL and testbench

Sequences physical operating-point changes for the chip's DVFS path: accepts a target (voltage level, frequency level) pair from the DVFS policy logic and drives the external voltage regulator (VR) and PLL handshakes in a safe order. Voltage rises before a frequency change and falls after it. The core clock is gated during PLL relock. Every wait is timeout-protected. Committed levels are reported back to the policy and power-state logic.

---
 rtl/pwr_pkg.sv | 20 ++
 rtl/dvfs_vf_sequencer_if.sv | 29 ++
 rtl/dvfs_wait_timer.sv | 33 +++
 rtl/dvfs_vf_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_dvfs_vf_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwr_pkg.sv
// Shared power-management types: sequencer states, error codes and level defaults.
package pwr_pkg;

  localparam int LEVEL_W_DEF     = 3;
  localparam int RESET_LEVEL_DEF = 4;

  typedef logic [LEVEL_W_DEF-1:0] level_t;

  typedef enum logic [3:0] {
    IDLE, VUP, FGATE, FRELOCK, FLOCK, VDN, SETTLE, DONE, ERROR
  } vf_state_e;

  typedef enum logic [1:0] {
    NONE        = 2'd0,
    VR_ACK_RISE = 2'd1,
    VR_ACK_FALL = 2'd2,
    PLL_LOCK    = 2'd3
  } err_code_e;

endpackage

// File: rtl/dvfs_vf_sequencer_if.sv
// Policy request plus VR and PLL handshakes; the sequencer is the slave side.
interface dvfs_vf_sequencer_if
  import pwr_pkg::*;
#(
  parameter int LEVEL_W = LEVEL_W_DEF
) ();

  logic               req_valid;
  logic               req_ready;
  logic [LEVEL_W-1:0] req_vlevel;
  logic [LEVEL_W-1:0] req_flevel;
  logic               vr_req;
  logic [LEVEL_W-1:0] vr_level;
  logic               vr_ack;
  logic               pll_relock;
  logic [LEVEL_W-1:0] pll_flevel;
  logic               pll_lock;

  modport master (
    output req_valid, req_vlevel, req_flevel, vr_ack, pll_lock,
    input  req_ready, vr_req, vr_level, pll_relock, pll_flevel
  );

  modport slave (
    input  req_valid, req_vlevel, req_flevel, vr_ack, pll_lock,
    output req_ready, vr_req, vr_level, pll_relock, pll_flevel
  );

endinterface

// File: rtl/dvfs_wait_timer.sv
// Loadable down-counter that saturates at zero; expired_o flags a zero count.
module dvfs_wait_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/dvfs_vf_sequencer.sv
// Orders VR and PLL steps for a DVFS change: voltage up first, frequency, voltage down last.
module dvfs_vf_sequencer
  import pwr_pkg::*;
#(
  parameter int LEVEL_W          = LEVEL_W_DEF,
  parameter int VR_SETTLE_CYCLES = 64,
  parameter int VR_TIMEOUT       = 1024,
  parameter int PLL_TIMEOUT      = 1024,
  parameter int RESET_LEVEL      = RESET_LEVEL_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  dvfs_vf_sequencer_if.slave    vf_bus,
  output logic                  clk_gate_en_o,
  output logic [LEVEL_W-1:0]    cur_vlevel_o,
  output logic [LEVEL_W-1:0]    cur_flevel_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  input  logic                  err_clr_i
);

  localparam int VR_MAX    = (VR_TIMEOUT > VR_SETTLE_CYCLES) ? VR_TIMEOUT : VR_SETTLE_CYCLES;
  localparam int VR_CNT_W  = $clog2(VR_MAX + 1);
  localparam int PLL_CNT_W = $clog2(PLL_TIMEOUT + 1);
  localparam logic [LEVEL_W-1:0] RST_LVL = LEVEL_W'(RESET_LEVEL);

  vf_state_e          state_q, state_d;
  err_code_e          err_code_q, err_code_d;
  logic [LEVEL_W-1:0] tv_q, tv_d, tf_q, tf_d;
  logic [LEVEL_W-1:0] cur_vlevel_q, cur_vlevel_d, cur_flevel_q, cur_flevel_d;
  logic [LEVEL_W-1:0] vr_level_q, vr_level_d, pll_flevel_q, pll_flevel_d;
  logic               req_ready_q, req_ready_d, busy_q, busy_d, done_q, done_d;
  logic               vr_req_q, vr_req_d, pll_relock_q, pll_relock_d;
  logic               clk_gate_en_q, clk_gate_en_d, err_q, err_d;

  logic               accept, in_vr_d, entering_vr;
  logic               vr_load, pll_load, vr_expired, pll_expired;
  logic [VR_CNT_W-1:0] vr_load_val;

  assign accept      = req_ready_q & vf_bus.req_valid;
  assign in_vr_d     = (state_d == VUP) || (state_d == VDN);
  assign entering_vr = in_vr_d && (state_d != state_q);

  // One VR timer serves ack-rise, ack-fall and settle; each wait reloads it on entry.
  assign vr_load     = entering_vr
                    || (in_vr_d && vr_req_q && vf_bus.vr_ack)
                    || ((state_d == SETTLE) && (state_q != SETTLE));
  assign vr_load_val = (state_d == SETTLE) ? VR_CNT_W'(VR_SETTLE_CYCLES - 1)
                                           : VR_CNT_W'(VR_TIMEOUT - 1);
  assign pll_load    = (state_d == FRELOCK) && (state_q != FRELOCK);

  dvfs_wait_timer #(.CNT_W(VR_CNT_W)) u_vr_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (vr_load),
    .load_val_i (vr_load_val),
    .expired_o  (vr_expired)
  );

  // The PLL budget spans FRELOCK and FLOCK together, so it loads only on relock entry.
  dvfs_wait_timer #(.CNT_W(PLL_CNT_W)) u_pll_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pll_load),
    .load_val_i (PLL_CNT_W'(PLL_TIMEOUT - 1)),
    .expired_o  (pll_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      err_code_q    <= NONE;
      tv_q          <= RST_LVL;
      tf_q          <= RST_LVL;
      cur_vlevel_q  <= RST_LVL;
      cur_flevel_q  <= RST_LVL;
      vr_level_q    <= RST_LVL;
      pll_flevel_q  <= RST_LVL;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      vr_req_q      <= 1'b0;
      pll_relock_q  <= 1'b0;
      clk_gate_en_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_code_q    <= err_code_d;
      tv_q          <= tv_d;
      tf_q          <= tf_d;
      cur_vlevel_q  <= cur_vlevel_d;
      cur_flevel_q  <= cur_flevel_d;
      vr_level_q    <= vr_level_d;
      pll_flevel_q  <= pll_flevel_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      vr_req_q      <= vr_req_d;
      pll_relock_q  <= pll_relock_d;
      clk_gate_en_q <= clk_gate_en_d;
      err_q         <= err_d;
    end
  end

  // In VUP/VDN a high vr_req_q means waiting for ack rise, low means waiting for ack fall.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (vf_bus.req_vlevel > cur_vlevel_q)       state_d = VUP;
          else if (vf_bus.req_flevel != cur_flevel_q) state_d = FGATE;
          else if (vf_bus.req_vlevel < cur_vlevel_q)  state_d = VDN;
          else                                        state_d = DONE;
        end
      end
      VUP, VDN: begin
        if (vr_req_q) begin
          if (!vf_bus.vr_ack && vr_expired) state_d = ERROR;
        end else if (!vf_bus.vr_ack) begin
          state_d = SETTLE;
        end else if (vr_expired) begin
          state_d = ERROR;
        end
      end
      SETTLE:  if (vr_expired) state_d = (tf_q != cur_flevel_q) ? FGATE : DONE;
      FGATE:   state_d = FRELOCK;
      FRELOCK: begin
        if (!vf_bus.pll_lock)  state_d = FLOCK;
        else if (pll_expired)  state_d = ERROR;
      end
      FLOCK: begin
        if (vf_bus.pll_lock)   state_d = (tv_q < cur_vlevel_q) ? VDN : DONE;
        else if (pll_expired)  state_d = ERROR;
      end
      DONE:    state_d = IDLE;
      ERROR:   if (err_clr_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tv_d         = accept ? vf_bus.req_vlevel : tv_q;
    tf_d         = accept ? vf_bus.req_flevel : tf_q;
    req_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    err_d        = (state_d == ERROR);
    vr_req_d     = entering_vr ? 1'b1 : (in_vr_d && vr_req_q && !vf_bus.vr_ack);
    vr_level_d   = entering_vr ? tv_d : vr_level_q;
    pll_relock_d = (state_d == FRELOCK);
    pll_flevel_d = pll_load ? tf_q : pll_flevel_q;

    err_code_d = err_code_q;
    if (state_d != ERROR) begin
      err_code_d = NONE;
    end else if (state_q != ERROR) begin
      if ((state_q == VUP) || (state_q == VDN)) err_code_d = vr_req_q ? VR_ACK_RISE : VR_ACK_FALL;
      else                                      err_code_d = PLL_LOCK;
    end

    clk_gate_en_d = (state_d == FGATE) || (state_d == FRELOCK) || (state_d == FLOCK)
                 || ((state_d == ERROR) && (err_code_d == PLL_LOCK));

    cur_vlevel_d = ((state_q == SETTLE) && (state_d != SETTLE)) ? tv_q : cur_vlevel_q;
    cur_flevel_d = ((state_q == FLOCK) && (state_d != FLOCK) && (state_d != ERROR))
                   ? tf_q : cur_flevel_q;
  end

  assign vf_bus.req_ready  = req_ready_q;
  assign vf_bus.vr_req     = vr_req_q;
  assign vf_bus.vr_level   = vr_level_q;
  assign vf_bus.pll_relock = pll_relock_q;
  assign vf_bus.pll_flevel = pll_flevel_q;
  assign clk_gate_en_o     = clk_gate_en_q;
  assign cur_vlevel_o      = cur_vlevel_q;
  assign cur_flevel_o      = cur_flevel_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign err_code_o        = err_code_q;

endmodule

// File: tb/tb_dvfs_vf_sequencer.sv
// Directed bench for dvfs_vf_sequencer with simple VR and PLL responders.
module tb_dvfs_vf_sequencer;
  import pwr_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   err_clr = 1'b0;
  logic   clk_gate_en, busy, done, err;
  level_t cur_v, cur_f;
  logic [1:0] err_code;

  dvfs_vf_sequencer_if #(.LEVEL_W(3)) vf ();

  dvfs_vf_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .vf_bus        (vf),
    .clk_gate_en_o (clk_gate_en),
    .cur_vlevel_o  (cur_v),
    .cur_flevel_o  (cur_f),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .err_code_o    (err_code),
    .err_clr_i     (err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // VR and PLL responders
  logic vr_en = 1'b1;
  int   vr_delay = 3;
  int   vr_cnt = 0;
  logic pll_fail = 1'b0;
  int   pll_delay = 20;
  int   pll_cnt = 0;

  initial begin
    vf.vr_ack   = 1'b0;
    vf.pll_lock = 1'b1;
    forever begin
      @(negedge clk);
      if (vr_en && vf.vr_req && !vf.vr_ack) begin
        vr_cnt++;
        if (vr_cnt >= vr_delay) begin
          vf.vr_ack = 1'b1;
          vr_cnt = 0;
        end
      end else if (!vf.vr_req && vf.vr_ack) begin
        vf.vr_ack = 1'b0;
      end
      if (vf.pll_relock && vf.pll_lock) begin
        vf.pll_lock = 1'b0;
        pll_cnt = 0;
      end else if (!vf.pll_relock && !vf.pll_lock && !pll_fail) begin
        pll_cnt++;
        if (pll_cnt >= pll_delay) vf.pll_lock = 1'b1;
      end
    end
  end

  // Event monitor: cyc equals the number of rising edges seen so far
  int cyc = 0;
  int n_done = 0, n_vr = 0, n_rel = 0, n_gate = 0;
  int t_curv = 0, t_curf = 0, t_vlvl = 0, t_gate = 0, t_err = 0, t_done = 0;
  logic p_vr = 1'b0, p_rel = 1'b0, p_gate = 1'b0, p_err = 1'b0;
  level_t p_cv = 3'd4, p_cf = 3'd4, p_vl = 3'd4;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (done) begin n_done++; t_done = cyc; end
      if (vf.vr_req && !p_vr) n_vr++;
      if (vf.pll_relock && !p_rel) n_rel++;
      if (clk_gate_en) n_gate++;
      if (clk_gate_en && !p_gate) t_gate = cyc;
      if (err && !p_err) t_err = cyc;
      if (cur_v !== p_cv) t_curv = cyc;
      if (cur_f !== p_cf) t_curf = cyc;
      if (vf.vr_level !== p_vl) t_vlvl = cyc;
      p_vr = vf.vr_req; p_rel = vf.pll_relock; p_gate = clk_gate_en; p_err = err;
      p_cv = cur_v; p_cf = cur_f; p_vl = vf.vr_level;
    end
  end

  int t_acc = 0;
  int s_done, s_vr, s_rel, s_gate;

  task automatic snap();
    s_done = n_done; s_vr = n_vr; s_rel = n_rel; s_gate = n_gate;
  endtask

  // Drive one request as soon as the sequencer is ready; returns at the negedge after accept.
  task automatic issue(input int v, input int f);
    int k;
    k = 0;
    @(negedge clk);
    while (!vf.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("ready_wait", vf.req_ready, 1);
    vf.req_vlevel = 3'(v);
    vf.req_flevel = 3'(f);
    vf.req_valid  = 1'b1;
    @(negedge clk);
    vf.req_valid  = 1'b0;
    t_acc = cyc;
  endtask

  task automatic pulse_busy_req();
    chk("busy_ready_low", vf.req_ready, 0);
    vf.req_vlevel = 3'd7;
    vf.req_flevel = 3'd7;
    vf.req_valid  = 1'b1;
    @(negedge clk);
    vf.req_valid  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic wait_err(input int budget);
    int k;
    k = 0;
    while (!err && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("err_seen", err, 1);
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"},  vf.req_ready, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_vr_req"}, vf.vr_req, 0);
    chk({tag, "_relock"}, vf.pll_relock, 0);
    chk({tag, "_gate"},   clk_gate_en, 0);
    chk({tag, "_done"},   done, 0);
    chk({tag, "_err"},    err, 0);
    chk({tag, "_code"},   err_code, 0);
    chk({tag, "_cur_v"},  cur_v, 4);
    chk({tag, "_cur_f"},  cur_f, 4);
    chk({tag, "_vr_lvl"}, vf.vr_level, 4);
    chk({tag, "_pll_fl"}, vf.pll_flevel, 4);
  endtask

  initial begin
    vf.req_valid  = 1'b0;
    vf.req_vlevel = 3'd0;
    vf.req_flevel = 3'd0;
    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready_rise", vf.req_ready, 1);

    // A: (4,4) -> (6,7): voltage up, settle, then relock
    snap();
    issue(6, 7);
    chk("A_busy", busy, 1);
    chk("A_ready", vf.req_ready, 0);
    chk("A_vr_req", vf.vr_req, 1);
    chk("A_vr_level", vf.vr_level, 6);
    wait_done(300);
    chk("A_cur_v", cur_v, 6);
    chk("A_cur_f", cur_f, 7);
    chk("A_t_curv", t_curv - t_acc, 68);
    chk("A_t_gate", t_gate - t_acc, 68);
    chk("A_t_curf", t_curf - t_acc, 90);
    chk("A_t_done", t_done - t_acc, 90);
    chk("A_gate_cycles", n_gate - s_gate, 22);
    chk("A_gate_off", clk_gate_en, 0);
    chk("A_vr_reqs", n_vr - s_vr, 1);
    chk("A_relocks", n_rel - s_rel, 1);
    @(negedge clk);
    chk("A_done_pulse", done, 0);
    chk("A_done_count", n_done - s_done, 1);
    $display("txn A: req (6,7) -> cur (%0d,%0d) done@+%0d", cur_v, cur_f, t_done - t_acc);

    // B: (6,7) -> (2,2): frequency first, then voltage down
    snap();
    issue(2, 2);
    chk("B_gate_first", clk_gate_en, 1);
    chk("B_no_vr_yet", vf.vr_req, 0);
    wait_done(300);
    chk("B_cur_v", cur_v, 2);
    chk("B_cur_f", cur_f, 2);
    chk("B_pll_fl", vf.pll_flevel, 2);
    chk("B_t_curf", t_curf - t_acc, 22);
    chk("B_order", (t_curf <= t_vlvl) ? 1 : 0, 1);
    chk("B_t_curv", t_curv - t_acc, 90);
    chk("B_gate_cycles", n_gate - s_gate, 22);
    chk("B_vr_reqs", n_vr - s_vr, 1);
    chk("B_relocks", n_rel - s_rel, 1);
    $display("txn B: req (2,2) -> cur (%0d,%0d) done@+%0d", cur_v, cur_f, t_done - t_acc);

    // D: VR never acknowledges
    vr_en = 1'b0;
    issue(5, 2);
    while (cyc < t_acc + 1000) @(negedge clk);
    chk("D_no_err_early", err, 0);
    wait_err(200);
    chk("D_t_err", t_err - t_acc, 1024);
    chk("D_code", err_code, 1);
    chk("D_cur_v", cur_v, 2);
    chk("D_cur_f", cur_f, 2);
    chk("D_vr_req", vf.vr_req, 0);
    chk("D_gate", clk_gate_en, 0);
    chk("D_ready", vf.req_ready, 0);
    clear_err();
    chk("D_clr_err", err, 0);
    chk("D_clr_code", err_code, 0);
    chk("D_clr_ready", vf.req_ready, 1);
    $display("txn D: req (5,2) -> err code 1 after %0d cycles", t_err - t_acc);
    vr_cnt = 0;
    vr_en  = 1'b1;

    // F: PLL never relocks
    pll_fail = 1'b1;
    issue(2, 5);
    chk("F_gate", clk_gate_en, 1);
    wait_err(1200);
    chk("F_t_err", t_err - t_acc, 1025);
    chk("F_code", err_code, 3);
    chk("F_gate_err", clk_gate_en, 1);
    chk("F_relock", vf.pll_relock, 0);
    chk("F_cur_f", cur_f, 2);
    repeat (10) @(negedge clk);
    chk("F_gate_held", clk_gate_en, 1);
    chk("F_err_held", err, 1);
    clear_err();
    chk("F_clr_gate", clk_gate_en, 0);
    chk("F_clr_code", err_code, 0);
    chk("F_clr_ready", vf.req_ready, 1);
    $display("txn F: req (2,5) -> err code 3 after %0d cycles", t_err - t_acc);
    pll_fail = 1'b0;
    repeat (30) @(negedge clk);

    // G1: requests offered while busy are dropped
    snap();
    issue(3, 2);
    repeat (4) @(negedge clk);
    pulse_busy_req();
    while (cyc < t_acc + 30) @(negedge clk);
    pulse_busy_req();
    wait_done(300);
    chk("G1_t_done", t_done - t_acc, 68);
    chk("G1_cur_v", cur_v, 3);
    chk("G1_cur_f", cur_f, 2);
    repeat (20) @(negedge clk);
    chk("G1_done_count", n_done - s_done, 1);
    chk("G1_idle", busy, 0);
    chk("G1_cur_v_kept", cur_v, 3);
    $display("txn G1: req (3,2) with busy pulses -> cur (%0d,%0d)", cur_v, cur_f);

    // G2: reset in the middle of SETTLE
    issue(6, 2);
    while (cyc < t_acc + 30) @(negedge clk);
    chk("G2_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_values("G2");
    rst = 1'b0;
    snap();
    @(negedge clk);
    chk("G2_ready_rise", vf.req_ready, 1);
    repeat (80) @(negedge clk);
    chk("G2_no_done", n_done - s_done, 0);
    chk("G2_cur_v", cur_v, 4);
    $display("txn G2: req (6,2) abandoned by reset -> cur (%0d,%0d)", cur_v, cur_f);

    // C: no-op request at (4,4)
    snap();
    issue(4, 4);
    chk("C_done_t1", done, 1);
    chk("C_ready_t1", vf.req_ready, 0);
    @(negedge clk);
    chk("C_ready_t2", vf.req_ready, 1);
    chk("C_done_t2", done, 0);
    chk("C_vr_reqs", n_vr - s_vr, 0);
    chk("C_relocks", n_rel - s_rel, 0);
    chk("C_done_count", n_done - s_done, 1);
    $display("txn C: req (4,4) no-op -> cur (%0d,%0d)", cur_v, cur_f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog");
  end

endmodule
